axi_stream_burst_writer: RTL and testbench

- Upstream AXI4 write master for the SDRAM/DDR memory path.
- Accepts a valid/ready word stream and buffers it in an internal FIFO.
- Packs the buffered words into INCR write bursts that never cross a 4 KiB boundary, and sends them to the memory slave's AW/W/B channels.
- Used by capture/DMA engines to move a programmed number of words to a base address. It keeps at most one burst outstanding.

---
 rtl/hydra_axi_pkg.sv | 20 ++
 rtl/axi_stream_burst_writer_if.sv | 55 +++++
 rtl/axi_wr_fifo.sv | 57 +++++
 rtl/axi_stream_burst_writer.sv | 177 +++++++++++++++++
 tb/tb_axi_stream_burst_writer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hydra_axi_pkg.sv
// Shared AXI constants, FSM state type and helpers for the burst writer.
package hydra_axi_pkg;

   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] BURST_INCR   = 2'b01;
   localparam int         AXI_4K_BYTES = 4096;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DATA,
      AW,
      W,
      B
   } wr_state_e;

   function automatic logic [2:0] axsize_for(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/axi_stream_burst_writer_if.sv
// Stream input plus AXI4 write channels (AW/W/B) of the burst writer.
interface axi_stream_burst_writer_if #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;

   logic [ID_WIDTH-1:0]   m_axi_awid;
   logic [ADDR_WIDTH-1:0] m_axi_awaddr;
   logic [7:0]            m_axi_awlen;
   logic [2:0]            m_axi_awsize;
   logic [1:0]            m_axi_awburst;
   logic                  m_axi_awvalid;
   logic                  m_axi_awready;

   logic [DATA_WIDTH-1:0] m_axi_wdata;
   logic [STRB_WIDTH-1:0] m_axi_wstrb;
   logic                  m_axi_wlast;
   logic                  m_axi_wvalid;
   logic                  m_axi_wready;

   logic [ID_WIDTH-1:0]   m_axi_bid;
   logic [1:0]            m_axi_bresp;
   logic                  m_axi_bvalid;
   logic                  m_axi_bready;

   // Writer side: consumes the stream, masters the AXI write channels.
   modport master (
      input  s_valid, s_data,
      output s_ready,
      output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
      output m_axi_bready
   );

   modport slave (
      output s_valid, s_data,
      input  s_ready,
      input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bid, m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready
   );

endinterface

// File: rtl/axi_wr_fifo.sv
// Synchronous first-word-fall-through FIFO buffering stream words ahead of W beats.
module axi_wr_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 32,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (PTR_W + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_stream_burst_writer.sv
// Stream-to-AXI4 write master: buffers words and issues 4 KiB-safe INCR bursts, one outstanding.
// Optional AXI_STREAM_BURST_WRITER_BRESP_CHECK_EN adds a sticky err flag for bad B responses.
module axi_stream_burst_writer
   import hydra_axi_pkg::*;
#(
   parameter int                  ADDR_WIDTH  = 28,
   parameter int                  DATA_WIDTH  = 64,
   parameter int                  STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int                  ID_WIDTH    = 4,
   parameter logic [ID_WIDTH-1:0] AXI_ID      = '0,
   parameter int                  BURST_BEATS = 16,
   parameter int                  FIFO_DEPTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_start,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [23:0]           cfg_words,
   output logic                  busy,
   output logic                  done,
`ifdef AXI_STREAM_BURST_WRITER_BRESP_CHECK_EN
   output logic                  err,
`endif
   axi_stream_burst_writer_if.master bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   wr_state_e             state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [23:0]           rem_words;
   logic [23:0]           in_left;
   logic [8:0]            blen_q;
   logic [8:0]            beat_cnt;
   logic [12:0]           beats_to_4k;
   logic [12:0]           blen_calc;

   logic                  s_ready_int;
   logic                  wvalid_int;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic [DATA_WIDTH-1:0] fifo_dout;

   assign s_ready_int = busy && !fifo_full && (in_left != 24'd0);
   assign fifo_push   = bus.s_valid && s_ready_int;
   assign wvalid_int  = (state == W) && !fifo_empty;
   assign fifo_pop    = wvalid_int && bus.m_axi_wready;

   axi_wr_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (bus.s_data),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // addr is beat-aligned, so the distance to the next 4 KiB page divides exactly.
   assign beats_to_4k = 13'((AXI_4K_BYTES - int'(addr[11:0])) / STRB_WIDTH);

   always_comb begin
      blen_calc = 13'(BURST_BEATS);
      if (rem_words < 24'(blen_calc)) begin
         blen_calc = rem_words[12:0];
      end
      if (beats_to_4k < blen_calc) begin
         blen_calc = beats_to_4k;
      end
   end

   assign bus.s_ready       = s_ready_int;
   assign bus.m_axi_awid    = AXI_ID;
   assign bus.m_axi_awaddr  = addr;
   assign bus.m_axi_awlen   = 8'(blen_q - 9'd1);
   assign bus.m_axi_awsize  = axsize_for(DATA_WIDTH);
   assign bus.m_axi_awburst = BURST_INCR;
   assign bus.m_axi_awvalid = (state == AW);
   assign bus.m_axi_wdata   = fifo_dout;
   assign bus.m_axi_wstrb   = '1;
   assign bus.m_axi_wlast   = (state == W) && (beat_cnt == 9'd1);
   assign bus.m_axi_wvalid  = wvalid_int;
   assign bus.m_axi_bready  = (state == B);

   // The burst length is frozen in blen_q on leaving WAIT_DATA so AW fields stay stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         rem_words <= '0;
         in_left   <= '0;
         blen_q    <= 9'd1;
         beat_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (fifo_push) begin
            in_left <= in_left - 24'd1;
         end
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  addr      <= cfg_base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
                  rem_words <= cfg_words;
                  in_left   <= cfg_words;
                  if (cfg_words == 24'd0) begin
                     done <= 1'b1;
                  end else begin
                     busy  <= 1'b1;
                     state <= WAIT_DATA;
                  end
               end
            end
            WAIT_DATA: begin
               if (int'(fifo_count) >= int'(blen_calc)) begin
                  blen_q <= blen_calc[8:0];
                  state  <= AW;
               end
            end
            AW: begin
               if (bus.m_axi_awready) begin
                  beat_cnt <= blen_q;
                  state    <= W;
               end
            end
            W: begin
               if (fifo_pop) begin
                  beat_cnt <= beat_cnt - 9'd1;
                  if (beat_cnt == 9'd1) begin
                     state <= B;
                  end
               end
            end
            B: begin
               if (bus.m_axi_bvalid) begin
                  addr      <= addr + ADDR_WIDTH'(int'(blen_q) * STRB_WIDTH);
                  rem_words <= rem_words - 24'(blen_q);
                  if (rem_words == 24'(blen_q)) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= WAIT_DATA;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AXI_STREAM_BURST_WRITER_BRESP_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (state == IDLE && cfg_start) begin
         err <= 1'b0;
      end else if (state == B && bus.m_axi_bvalid &&
                   (bus.m_axi_bresp != RESP_OKAY || bus.m_axi_bid != AXI_ID)) begin
         err <= 1'b1;
      end
   end
`else
   logic unused_b_fields;
   assign unused_b_fields = ^{bus.m_axi_bid, bus.m_axi_bresp};
`endif

endmodule

// File: tb/tb_axi_stream_burst_writer.sv
// Randomized bench for axi_stream_burst_writer with a memory-slave model and burst-plan reference.
// Exercises the err flag when AXI_STREAM_BURST_WRITER_BRESP_CHECK_EN is defined.
module tb_axi_stream_burst_writer;

   localparam int ADDR_WIDTH = 28;
   localparam int DATA_WIDTH = 64;
   localparam int ID_WIDTH   = 4;
   localparam int MAX_BEATS  = 16;
   localparam int BYTES      = DATA_WIDTH / 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cfg_start;
   logic [ADDR_WIDTH-1:0] cfg_base_addr;
   logic [23:0]           cfg_words;
   logic                  busy;
   logic                  done;
`ifdef AXI_STREAM_BURST_WRITER_BRESP_CHECK_EN
   logic                  err;
`endif

   axi_stream_burst_writer_if #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH)
   ) bus ();

   axi_stream_burst_writer #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .ID_WIDTH    (ID_WIDTH),
      .AXI_ID      (4'd0),
      .BURST_BEATS (MAX_BEATS),
      .FIFO_DEPTH  (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_words     (cfg_words),
      .busy          (busy),
      .done          (done),
`ifdef AXI_STREAM_BURST_WRITER_BRESP_CHECK_EN
      .err           (err),
`endif
      .bus           (bus)
   );

   always #5 clk = ~clk;

   int compare_count  = 0;
   int mismatch_count = 0;

   // Stream source state
   int                    stream_idx   = 0;
   int                    stream_total = 0;
   int                    gap_mode     = 0;
   int                    gap_cnt      = 0;
   bit                    offering     = 0;
   logic [DATA_WIDTH-1:0] stream_base  = '0;

   // Memory slave state and observation logs
   logic [DATA_WIDTH-1:0] mem [logic [ADDR_WIDTH-1:0]];
   logic [ADDR_WIDTH-1:0] got_addr [$];
   int                    got_len  [$];
   int                    aw_delay_cfg = 0;
   bit                    w_rand_cfg   = 0;
   bit                    bresp_err_cfg = 0;
   int                    aw_wait = 0;
   bit                    aw_seen = 0;
   logic [ADDR_WIDTH-1:0] hold_addr;
   logic [7:0]            hold_len;
   bit                    in_flight = 0;
   logic [ADDR_WIDTH-1:0] cur_addr;
   int                    beats_left = 0;
   bit                    b_pending = 0;
   int                    b_count = 0;
   int                    beats_seen = 0;
   int                    wlast_count = 0;
   int                    wlast_err = 0;
   int                    order_err = 0;
   int                    stable_err = 0;
   int                    const_err = 0;
   int                    cross_err = 0;
   bit                    first_aw_pending = 0;
   int                    first_aw_words = 0;
   int                    done_count = 0;
   logic [ADDR_WIDTH-1:0] job_base;
   int                    job_words;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Stream source: holds each offered word until accepted, optional idle gaps between words.
   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      forever begin
         @(negedge clk);
         if (!offering && stream_idx < stream_total) begin
            if (gap_cnt == 0) offering = 1;
            else gap_cnt--;
         end
         bus.s_valid = offering;
         bus.s_data  = stream_base + 64'(stream_idx);
         if (offering && bus.s_ready) begin
            stream_idx++;
            offering = 0;
            gap_cnt  = (gap_mode == 1) ? 3 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
         end
      end
   end

   // Memory slave: every handshake decided here completes at the following posedge.
   initial begin
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_bvalid  = 1'b0;
      bus.m_axi_bid     = '0;
      bus.m_axi_bresp   = 2'b00;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.m_axi_awready = 1'b0;
            bus.m_axi_wready  = 1'b0;
            bus.m_axi_bvalid  = 1'b0;
         end else begin
            bus.m_axi_bvalid = b_pending;
            bus.m_axi_bid    = 4'd0;
            bus.m_axi_bresp  = (bresp_err_cfg && b_count == 0) ? 2'b10 : 2'b00;
            if (b_pending && bus.m_axi_bready) begin
               b_pending = 0;
               in_flight = 0;
               b_count++;
            end

            if (bus.m_axi_awvalid) begin
               if (in_flight) order_err++;
               if (!aw_seen) begin
                  aw_seen   = 1;
                  aw_wait   = aw_delay_cfg;
                  hold_addr = bus.m_axi_awaddr;
                  hold_len  = bus.m_axi_awlen;
                  if (first_aw_pending) begin
                     first_aw_words   = stream_idx;
                     first_aw_pending = 0;
                  end
               end else if (bus.m_axi_awaddr !== hold_addr || bus.m_axi_awlen !== hold_len) begin
                  stable_err++;
               end
               bus.m_axi_awready = (aw_wait == 0);
               if (aw_wait > 0) aw_wait--;
            end else begin
               bus.m_axi_awready = 1'b0;
            end
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
               got_addr.push_back(bus.m_axi_awaddr);
               got_len.push_back(int'(bus.m_axi_awlen));
               if (bus.m_axi_awid !== 4'd0 || bus.m_axi_awsize !== 3'd3 || bus.m_axi_awburst !== 2'b01)
                  const_err++;
               if (int'(bus.m_axi_awaddr[11:0]) + (int'(bus.m_axi_awlen) + 1) * BYTES > 4096)
                  cross_err++;
               aw_seen    = 0;
               in_flight  = 1;
               cur_addr   = bus.m_axi_awaddr;
               beats_left = int'(bus.m_axi_awlen) + 1;
            end

            bus.m_axi_wready = w_rand_cfg ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
               if (!in_flight || beats_left == 0) begin
                  order_err++;
               end else begin
                  mem[cur_addr] = bus.m_axi_wdata;
                  if (bus.m_axi_wstrb !== 8'hFF) const_err++;
                  if (bus.m_axi_wlast !== (beats_left == 1)) wlast_err++;
                  if (bus.m_axi_wlast) wlast_count++;
                  cur_addr = cur_addr + ADDR_WIDTH'(BYTES);
                  beats_left--;
                  beats_seen++;
                  if (beats_left == 0) b_pending = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && done) done_count++;
   end

   task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] base, input int words, input int aw_delay,
                                input bit w_rand, input int gmode, input bit bresp_err);
      @(negedge clk);
      mem.delete();
      got_addr.delete();
      got_len.delete();
      stream_base      = {$urandom, $urandom};
      stream_idx       = 0;
      stream_total     = words;
      gap_mode         = gmode;
      gap_cnt          = 0;
      offering         = 0;
      aw_delay_cfg     = aw_delay;
      w_rand_cfg       = w_rand;
      bresp_err_cfg    = bresp_err;
      aw_seen          = 0;
      in_flight        = 0;
      b_pending        = 0;
      b_count          = 0;
      beats_seen       = 0;
      wlast_count      = 0;
      wlast_err        = 0;
      order_err        = 0;
      stable_err       = 0;
      const_err        = 0;
      cross_err        = 0;
      first_aw_pending = 1;
      done_count       = 0;
      job_base         = base;
      job_words        = words;
      cfg_start        = 1'b1;
      cfg_base_addr    = base;
      cfg_words        = 24'(words);
      @(negedge clk);
      cfg_start        = 1'b0;
   endtask

   // Waits for the job and compares the observed bursts and memory against the burst plan.
   task automatic checkJob(input string name);
      logic [ADDR_WIDTH-1:0] exp_addr [$];
      int                    exp_len [$];
      logic [ADDR_WIDTH-1:0] a;
      int                    r, len, to4k, cycles, data_err, n;
      cycles = 0;
      while (done_count == 0 && cycles < 4000) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({name, "_done_seen"}, 64'(done_count != 0), 1);
      repeat (3) @(negedge clk);
      checkOutput({name, "_done_once"}, 64'(done_count), 1);
      checkOutput({name, "_busy_low"}, 64'(busy), 0);

      a = job_base & ~ADDR_WIDTH'(BYTES - 1);
      r = job_words;
      while (r > 0) begin
         to4k = (4096 - int'(a[11:0])) / BYTES;
         len  = r;
         if (len > MAX_BEATS) len = MAX_BEATS;
         if (len > to4k) len = to4k;
         exp_addr.push_back(a);
         exp_len.push_back(len - 1);
         a = a + ADDR_WIDTH'(len * BYTES);
         r = r - len;
      end
      checkOutput({name, "_burst_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_awaddr%0d", name, i), 64'(got_addr[i]), 64'(exp_addr[i]));
         checkOutput($sformatf("%s_awlen%0d", name, i), 64'(got_len[i]), 64'(exp_len[i]));
      end
      checkOutput({name, "_4k_cross"}, 64'(cross_err), 0);
      checkOutput({name, "_wlast_pos"}, 64'(wlast_err), 0);
      checkOutput({name, "_wlast_count"}, 64'(wlast_count), 64'(exp_addr.size()));
      checkOutput({name, "_beats"}, 64'(beats_seen), 64'(job_words));
      checkOutput({name, "_ordering"}, 64'(order_err), 0);
      checkOutput({name, "_aw_stable"}, 64'(stable_err), 0);
      checkOutput({name, "_const_fields"}, 64'(const_err), 0);

      data_err = 0;
      a = job_base & ~ADDR_WIDTH'(BYTES - 1);
      for (int i = 0; i < job_words; i++) begin
         if (!mem.exists(a) || mem[a] !== stream_base + 64'(i)) data_err++;
         a = a + ADDR_WIDTH'(BYTES);
      end
      checkOutput({name, "_readback"}, 64'(data_err), 0);
      checkOutput({name, "_write_count"}, 64'(mem.size()), 64'(job_words));
   endtask

   task automatic checkIdleOutputs(input string name);
      checkOutput({name, "_busy"}, 64'(busy), 0);
      checkOutput({name, "_done"}, 64'(done), 0);
      checkOutput({name, "_s_ready"}, 64'(bus.s_ready), 0);
      checkOutput({name, "_valids"}, 64'({bus.m_axi_awvalid, bus.m_axi_wvalid}), 0);
      checkOutput({name, "_bready"}, 64'(bus.m_axi_bready), 0);
   endtask

   initial begin
      int cycles;
      rst           = 1'b1;
      cfg_start     = 1'b0;
      cfg_base_addr = '0;
      cfg_words     = '0;
      repeat (3) @(negedge clk);
      checkIdleOutputs("reset");
`ifdef AXI_STREAM_BURST_WRITER_BRESP_CHECK_EN
      checkOutput("reset_err", 64'(err), 0);
`endif
      rst = 1'b0;
      $display("[TB] reset released");

      applyStimulus(28'h000, 40, 0, 0, 0, 0);
      checkJob("basic40");

      applyStimulus(28'hFE0, 8, 0, 0, 0, 0);
      checkJob("page_split");

      applyStimulus(28'h300, 0, 0, 0, 0, 0);
      checkOutput("zero_done_pulse", 64'(done), 1);
      checkOutput("zero_busy", 64'(busy), 0);
      @(negedge clk);
      checkOutput("zero_done_drop", 64'(done), 0);
      repeat (10) @(negedge clk);
      checkOutput("zero_no_aw", 64'(got_addr.size()), 0);

      applyStimulus(28'h200, 37, 5, 1, 2, 0);
      checkJob("stall");

      applyStimulus(28'h400, 20, 0, 0, 1, 0);
      checkJob("trickle");
      checkOutput("trickle_first_aw_buffered", 64'(first_aw_words >= 16), 1);

      applyStimulus(28'hFFF_FF80, 24, 0, 1, 0, 0);
      checkJob("addr_wrap");

      // Abandon a burst mid-W with reset, then confirm a fresh job is unaffected.
      applyStimulus(28'h800, 40, 0, 1, 0, 0);
      cycles = 0;
      while (beats_seen < 3 && cycles < 500) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("midw_beats_reached", 64'(beats_seen >= 3), 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 checkIdleOutputs("midw_reset");
      repeat (2) @(negedge clk);
      stream_total = 0;
      in_flight    = 0;
      b_pending    = 0;
      aw_seen      = 0;
      rst          = 1'b0;
      checkOutput("midw_fifo_empty", 64'(bus.m_axi_wvalid), 0);
      applyStimulus(28'hA40, 30, 2, 1, 2, 0);
      checkJob("after_reset");

      for (int j = 0; j < 4; j++) begin
         applyStimulus(28'($urandom) & ~28'h7, int'($urandom_range(1, 60)), int'($urandom_range(0, 3)), 1, 2, 0);
         checkJob($sformatf("rand%0d", j));
      end

`ifdef AXI_STREAM_BURST_WRITER_BRESP_CHECK_EN
      applyStimulus(28'h1000, 20, 0, 0, 0, 1);
      checkJob("bresp_bad");
      checkOutput("err_set", 64'(err), 1);
      applyStimulus(28'h2000, 10, 0, 0, 0, 0);
      checkOutput("err_cleared_on_start", 64'(err), 0);
      checkJob("bresp_ok");
      checkOutput("err_stays_clear", 64'(err), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
